// File: rtl/lcd_pkg.sv
// Shared types, bit positions and init ROM for the HD44780 sequencer.
// Helper functions keep the timer load values and long-command decode in one place.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } lcd_state_e;

    localparam int LCD_ON = 31;
    localparam int LCD_EN = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    localparam int INIT_LEN = 6;
    localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear display / return home variants need the long busy wait
    localparam int LONG_LEN = 3;
    localparam logic [7:0] LONG_CMDS [LONG_LEN] = '{8'h01, 8'h02, 8'h03};

    function automatic int unsigned cyc_min1(input int unsigned n);
        return (n == 0) ? 32'd1 : n;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < LONG_LEN; i++) begin
            if (data == LONG_CMDS[i]) hit = 1'b1;
        end
        return hit && !rs;
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < INIT_LEN; i++) begin
            if (idx == 3'(i)) b = INIT_SEQ[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Shared down-counter: a load of N keeps the owning state for N cycles.
// Saturates at zero; expired while the count is 1 (or 0).
module lcd_timer #(
    parameter int          W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= RST_VAL;
        else       cnt_q <= cnt_d;
    end

    assign o_expired = (cnt_q <= W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up init, then timed command/data writes
// accepted over a valid/ready handshake and driven onto the board LCD word.
//
// state   | meaning
// S_PWRUP | post-reset power-up delay
// S_SETUP | RS/DATA stable, EN low
// S_PULSE | EN high
// S_HOLD  | EN low, RS/DATA held
// S_WAIT  | controller execution time (long for clear/home)
// S_IDLE  | ready for a byte
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 25,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned EXEC_CYC  = 2500,
    parameter int unsigned LONG_CYC  = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_vld,
    input  logic        i_wr_rs,
    input  logic [7:0]  i_wr_data,
    output logic        o_wr_rdy,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(cyc_min1(PWRUP_CYC), cyc_min1(SETUP_CYC)),
                                                  max_u(cyc_min1(PULSE_CYC), cyc_min1(HOLD_CYC))),
                                            max_u(cyc_min1(EXEC_CYC), cyc_min1(LONG_CYC)));
    localparam int TW = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] T_PWRUP = TW'(cyc_min1(PWRUP_CYC));
    localparam logic [TW-1:0] T_SETUP = TW'(cyc_min1(SETUP_CYC));
    localparam logic [TW-1:0] T_PULSE = TW'(cyc_min1(PULSE_CYC));
    localparam logic [TW-1:0] T_HOLD  = TW'(cyc_min1(HOLD_CYC));
    localparam logic [TW-1:0] T_EXEC  = TW'(cyc_min1(EXEC_CYC));
    localparam logic [TW-1:0] T_LONG  = TW'(cyc_min1(LONG_CYC));
    localparam logic [2:0]    LAST_IDX = 3'(INIT_LEN - 1);

    lcd_state_e    state_q, state_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_exp;
    logic          accept;

    logic          on_q, on_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          done_q, done_d;
    logic [2:0]    idx_q, idx_d;

    lcd_timer #(
        .W       (TW),
        .RST_VAL (T_PWRUP)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (tmr_load),
        .i_value   (tmr_val),
        .o_expired (tmr_exp)
    );

    assign accept = (state_q == S_IDLE) && rdy_q && i_wr_vld;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_PWRUP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = T_SETUP;
        unique case (state_q)
            S_PWRUP: if (tmr_exp) begin
                state_d  = S_SETUP;
                tmr_load = 1'b1;
                tmr_val  = T_SETUP;
            end
            S_SETUP: if (tmr_exp) begin
                state_d  = S_PULSE;
                tmr_load = 1'b1;
                tmr_val  = T_PULSE;
            end
            S_PULSE: if (tmr_exp) begin
                state_d  = S_HOLD;
                tmr_load = 1'b1;
                tmr_val  = T_HOLD;
            end
            S_HOLD: if (tmr_exp) begin
                state_d  = S_WAIT;
                tmr_load = 1'b1;
                tmr_val  = is_long_cmd(rs_q, data_q) ? T_LONG : T_EXEC;
            end
            S_WAIT: if (tmr_exp) begin
                if (idx_q < LAST_IDX) begin
                    state_d  = S_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = T_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: if (accept) begin
                state_d  = S_SETUP;
                tmr_load = 1'b1;
                tmr_val  = T_SETUP;
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // Outputs are registered from the next state so they change with the state
    always_comb begin
        on_d   = 1'b1;
        en_d   = (state_d == S_PULSE);
        rdy_d  = (state_d == S_IDLE);
        done_d = done_q;
        rs_d   = rs_q;
        data_d = data_q;
        idx_d  = idx_q;
        if (state_q == S_PWRUP && tmr_exp) begin
            rs_d   = 1'b0;
            data_d = init_byte(3'd0);
        end else if (state_q == S_WAIT && tmr_exp) begin
            if (idx_q < LAST_IDX) begin
                idx_d  = idx_q + 3'd1;
                rs_d   = 1'b0;
                data_d = init_byte(idx_q + 3'd1);
            end else begin
                done_d = 1'b1;
            end
        end else if (accept) begin
            rs_d   = i_wr_rs;
            data_d = i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            on_q   <= 1'b0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= 3'd0;
        end else begin
            on_q   <= on_d;
            en_q   <= en_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            rdy_q  <= rdy_d;
            done_q <= done_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        o_io_lcd         = 32'h0;
        o_io_lcd[LCD_ON] = on_q;
        o_io_lcd[LCD_EN] = en_q;
        o_io_lcd[LCD_RS] = rs_q;
        o_io_lcd[LCD_RW] = 1'b0;
        o_io_lcd[7:0]    = data_q;
    end

    assign o_wr_rdy    = rdy_q;
    assign o_init_done = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
// An EN edge monitor logs every pulse; scenario tasks check against hand-derived cycle numbers.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_vld = 1'b0;
    logic        wr_rs = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_rdy;
    logic        init_done;
    logic [31:0] io_lcd;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rel = 0;
    int rbase = 0;
    int fbase = 0;
    int bad_bits = 0;

    int         rise_cyc[$];
    int         fall_cyc[$];
    logic [7:0] rise_data[$];
    logic       rise_rs[$];
    logic       en_prev = 1'b0;

    lcd_ctrl #(
        .PWRUP_CYC (20),
        .SETUP_CYC (2),
        .PULSE_CYC (3),
        .HOLD_CYC  (2),
        .EXEC_CYC  (10),
        .LONG_CYC  (40)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_vld    (wr_vld),
        .i_wr_rs     (wr_rs),
        .i_wr_data   (wr_data),
        .o_wr_rdy    (wr_rdy),
        .o_init_done (init_done),
        .o_io_lcd    (io_lcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_lcd[10] === 1'b1 && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(io_lcd[7:0]);
            rise_rs.push_back(io_lcd[9]);
        end
        if (io_lcd[10] !== 1'b1 && en_prev) fall_cyc.push_back(cyc);
        en_prev = (io_lcd[10] === 1'b1);
        if (!rst && ($isunknown(io_lcd) || io_lcd[30:11] != 20'h0 || io_lcd[8] != 1'b0)) bad_bits++;
    end

    task automatic send_byte(input logic rs, input logic [7:0] d, output int acc,
                             output int busy, output logic [31:0] w, output logic rdy_after);
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        wr_vld  = 1'b1;
        wr_rs   = rs;
        wr_data = d;
        @(posedge clk);
        #1;
        acc       = cyc;
        w         = io_lcd;
        rdy_after = wr_rdy;
        wr_vld    = 1'b0;
        n = 0;
        busy = -1;
        while (n < 300) begin
            @(negedge clk);
            if (wr_rdy) begin
                busy = cyc - acc + 1;
                break;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (io_lcd !== 32'h0) $display("FAIL reset_lcd: got %h want %h", io_lcd, 32'h0); else n_pass++;
        n_chk++; if (wr_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", wr_rdy); else n_pass++;
        n_chk++; if (init_done !== 1'b0) $display("FAIL reset_done: got %b want 0", init_done); else n_pass++;
        rst = 1'b0;
        rel = cyc;
        #1;
        rbase = rise_cyc.size();
        fbase = fall_cyc.size();
        @(posedge clk);
        #1;
        n_chk++; if (io_lcd !== 32'h8000_0000) $display("FAIL first_clk_on: got %h want %h", io_lcd, 32'h8000_0000); else n_pass++;
    endtask

    task automatic test_init(input bit poke, input string tag);
        int done_cyc;
        int rdy_early;
        int exp_r;
        int d;
        int nr;
        logic [7:0] exp_d[6];
        int gap[6];
        exp_d = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        gap = '{17, 17, 17, 17, 47, 15};
        done_cyc = -1;
        rdy_early = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (wr_rdy !== 1'b0) rdy_early++;
            if (poke) begin
                d = cyc - rel;
                wr_vld  = (d >= 5 && d <= 7) || (d >= 40 && d <= 42) || (d >= 100 && d <= 103);
                wr_rs   = 1'b1;
                wr_data = 8'h55;
            end
        end
        wr_vld = 1'b0;
        nr = rise_cyc.size() - rbase;
        n_chk++; if (nr != 6) $display("FAIL %s_pulse_count: got %0d want 6", tag, nr); else n_pass++;
        exp_r = rel + 22;
        if (nr >= 6 && fall_cyc.size() - fbase >= 6) begin
            for (int k = 0; k < 6; k++) begin
                n_chk++; if (rise_data[rbase+k] !== exp_d[k]) $display("FAIL %s_data%0d: got %h want %h", tag, k, rise_data[rbase+k], exp_d[k]); else n_pass++;
                n_chk++; if (rise_rs[rbase+k] !== 1'b0) $display("FAIL %s_rs%0d: got %b want 0", tag, k, rise_rs[rbase+k]); else n_pass++;
                n_chk++; if (rise_cyc[rbase+k] != exp_r) $display("FAIL %s_rise%0d: got cycle %0d want %0d", tag, k, rise_cyc[rbase+k] - rel, exp_r - rel); else n_pass++;
                n_chk++; if (fall_cyc[fbase+k] - rise_cyc[rbase+k] != 3) $display("FAIL %s_width%0d: got %0d want 3", tag, k, fall_cyc[fbase+k] - rise_cyc[rbase+k]); else n_pass++;
                exp_r += gap[k];
            end
        end else begin
            exp_r = rel + 152;
        end
        n_chk++; if (done_cyc != exp_r) $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_cyc - rel, exp_r - rel); else n_pass++;
        n_chk++; if (wr_rdy !== 1'b1) $display("FAIL %s_rdy_at_done: got %b want 1", tag, wr_rdy); else n_pass++;
        n_chk++; if (rdy_early != 0) $display("FAIL %s_rdy_during_init: got %0d want 0", tag, rdy_early); else n_pass++;
    endtask

    task automatic test_single();
        int acc, busy, rb, fb;
        logic [31:0] w;
        logic ra;
        rb = rise_cyc.size();
        fb = fall_cyc.size();
        send_byte(1'b1, 8'h41, acc, busy, w, ra);
        n_chk++; if (w !== 32'h8000_0241) $display("FAIL single_word: got %h want %h", w, 32'h8000_0241); else n_pass++;
        n_chk++; if (ra !== 1'b0) $display("FAIL single_rdy_drop: got %b want 0", ra); else n_pass++;
        n_chk++; if (busy != 18) $display("FAIL single_busy: got %0d want 18", busy); else n_pass++;
        n_chk++; if (rise_cyc.size() - rb != 1) $display("FAIL single_pulses: got %0d want 1", rise_cyc.size() - rb); else n_pass++;
        if (rise_cyc.size() > rb && fall_cyc.size() > fb) begin
            n_chk++; if (rise_cyc[rb] - acc + 1 != 3) $display("FAIL single_en_rise: got cycle %0d want 3", rise_cyc[rb] - acc + 1); else n_pass++;
            n_chk++; if (fall_cyc[fb] - rise_cyc[rb] != 3) $display("FAIL single_en_width: got %0d want 3", fall_cyc[fb] - rise_cyc[rb]); else n_pass++;
            n_chk++; if (rise_data[rb] !== 8'h41 || rise_rs[rb] !== 1'b1) $display("FAIL single_en_data: got %b/%h want 1/41", rise_rs[rb], rise_data[rb]); else n_pass++;
        end
    endtask

    task automatic test_long();
        int acc, busy;
        logic [31:0] w;
        logic ra;
        send_byte(1'b0, 8'h01, acc, busy, w, ra);
        n_chk++; if (busy != 48) $display("FAIL long_cmd_busy: got %0d want 48", busy); else n_pass++;
        send_byte(1'b1, 8'h01, acc, busy, w, ra);
        n_chk++; if (busy != 18) $display("FAIL char01_busy: got %0d want 18", busy); else n_pass++;
        send_byte(1'b0, 8'h03, acc, busy, w, ra);
        n_chk++; if (busy != 48) $display("FAIL long_cmd03_busy: got %0d want 48", busy); else n_pass++;
        send_byte(1'b0, 8'h04, acc, busy, w, ra);
        n_chk++; if (busy != 18) $display("FAIL cmd04_busy: got %0d want 18", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int k, rb;
        rb = rise_cyc.size();
        k = 0;
        acc = '{0, 0};
        @(negedge clk);
        wr_vld  = 1'b1;
        wr_rs   = 1'b1;
        wr_data = 8'h48;
        for (int i = 0; i < 200 && k < 2; i++) begin
            if (wr_rdy === 1'b1) begin
                @(posedge clk);
                #1;
                acc[k] = cyc;
                k++;
                if (k == 1) wr_data = 8'h49;
                else        wr_vld  = 1'b0;
            end
            @(negedge clk);
        end
        wr_vld = 1'b0;
        repeat (40) @(negedge clk);
        n_chk++; if (k != 2) $display("FAIL b2b_accepts: got %0d want 2", k); else n_pass++;
        n_chk++; if (acc[1] - acc[0] != 18) $display("FAIL b2b_spacing: got %0d want 18", acc[1] - acc[0]); else n_pass++;
        n_chk++; if (rise_cyc.size() - rb != 2) $display("FAIL b2b_pulses: got %0d want 2", rise_cyc.size() - rb); else n_pass++;
        if (rise_cyc.size() - rb >= 2) begin
            n_chk++; if (rise_data[rb] !== 8'h48 || rise_data[rb+1] !== 8'h49) $display("FAIL b2b_data: got %h,%h want 48,49", rise_data[rb], rise_data[rb+1]); else n_pass++;
            n_chk++; if (rise_cyc[rb+1] - rise_cyc[rb] != 18) $display("FAIL b2b_pulse_spacing: got %0d want 18", rise_cyc[rb+1] - rise_cyc[rb]); else n_pass++;
            n_chk++; if (rise_cyc[rb] - acc[0] != 2) $display("FAIL b2b_first_rise: got %0d want 2", rise_cyc[rb] - acc[0]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        wr_vld  = 1'b1;
        wr_rs   = 1'b1;
        wr_data = 8'h5A;
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        n = 0;
        while (io_lcd[10] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        n_chk++; if (io_lcd[10] !== 1'b1) $display("FAIL midpulse_en_before: got %b want 1", io_lcd[10]); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (io_lcd !== 32'h0) $display("FAIL midpulse_lcd: got %h want %h", io_lcd, 32'h0); else n_pass++;
        n_chk++; if (init_done !== 1'b0) $display("FAIL midpulse_done: got %b want 0", init_done); else n_pass++;
        n_chk++; if (wr_rdy !== 1'b0) $display("FAIL midpulse_rdy: got %b want 0", wr_rdy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        #1;
        rbase = rise_cyc.size();
        fbase = fall_cyc.size();
    endtask

    task automatic test_reserved_bits();
        n_chk++; if (bad_bits != 0) $display("FAIL reserved_bits: got %0d bad samples want 0", bad_bits); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init(1'b0, "init");
        test_single();
        test_long();
        test_back_to_back();
        test_reset_mid_pulse();
        test_init(1'b1, "reinit_vld");
        test_reserved_bits();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
